// File: rtl/lag_channel_rx_buffer.sv
// lag_channel_rx_buffer: credit-returning FWFT receive FIFO for a router-to-router channel
module lag_channel_rx_buffer #(
  parameter int FLIT_W = 64,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic              flit_valid_in,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_valid_out,
  input  logic              flit_ready_in,
  output logic              credit_out,
  output logic [CNT_W-1:0]  occupancy,
  output logic              overflow_err
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic full, pop, wr_en;
  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return p == PTR_W'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full = occupancy == CNT_W'(DEPTH);
  assign pop = flit_valid_out & flit_ready_in;
  // a push into a full buffer only lands when the same cycle's pop frees a slot
  assign wr_en = flit_valid_in & (~full | pop);
  assign flit_valid_out = occupancy != '0;
  assign flit_out = flit_valid_out ? mem[rd_ptr] : '0;
  // storage is deliberately left unreset; occupancy gates what is visible
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= flit_in;
  end
  // pointers, occupancy, credit return and the sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occupancy <= '0;
      credit_out <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      wr_ptr <= wr_en ? inc(wr_ptr) : wr_ptr;
      rd_ptr <= pop ? inc(rd_ptr) : rd_ptr;
      occupancy <= occupancy + CNT_W'(wr_en) - CNT_W'(pop);
      credit_out <= pop;
      overflow_err <= overflow_err | (flit_valid_in & full & ~pop);
    end
  end
endmodule

// File: tb/tb_lag_channel_rx_buffer.sv
// tb_lag_channel_rx_buffer: scoreboard bench, directed DEPTH=4 plus streamed DEPTH=3 instance
module tb_lag_channel_rx_buffer;
  logic clk = 1'b0;
  logic rst4 = 1'b1, rst3 = 1'b1;
  logic [63:0] flit_in4 = '0, flit_in3 = '0, flit_out4, flit_out3;
  logic flit_valid_in4 = 1'b0, flit_valid_in3 = 1'b0, flit_ready_in4 = 1'b0, flit_ready_in3 = 1'b0;
  logic flit_valid_out4, flit_valid_out3, credit_out4, credit_out3, overflow_err4, overflow_err3;
  logic [2:0] occupancy4;
  logic [1:0] occupancy3;
  logic [63:0] q4[$], q3[$];
  logic pp4 = 1'b0, pp3 = 1'b0;
  int vecs = 0, errs = 0, tx = 3;

  always #5 clk = ~clk;

  lag_channel_rx_buffer #(.FLIT_W(64), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst4), .flit_in(flit_in4), .flit_valid_in(flit_valid_in4),
    .flit_out(flit_out4), .flit_valid_out(flit_valid_out4), .flit_ready_in(flit_ready_in4),
    .credit_out(credit_out4), .occupancy(occupancy4), .overflow_err(overflow_err4));

  lag_channel_rx_buffer #(.FLIT_W(64), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst3), .flit_in(flit_in3), .flit_valid_in(flit_valid_in3),
    .flit_out(flit_out3), .flit_valid_out(flit_valid_out3), .flit_ready_in(flit_ready_in3),
    .credit_out(credit_out3), .occupancy(occupancy3), .overflow_err(overflow_err3));

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // monitor for the DEPTH=4 instance: pops the scoreboard whenever a flit is consumed
  always @(negedge clk) begin
    if (rst4) pp4 = 1'b0;
    else begin
      chk("credit4", 64'(credit_out4), 64'(pp4));
      chk("occ4", 64'(occupancy4), 64'(q4.size()));
      chk("valid4", 64'(flit_valid_out4), 64'(q4.size() != 0));
      if (q4.size() == 0) chk("empty_out4", flit_out4, 64'h0);
      if (flit_valid_out4 && flit_ready_in4) begin
        if (q4.size() == 0) chk("underflow4", 64'(flit_valid_out4), 64'h0);
        else chk("data4", flit_out4, q4.pop_front());
      end
      pp4 = flit_valid_out4 && flit_ready_in4;
    end
  end

  // monitor for the DEPTH=3 instance, including the credit conservation invariant
  always @(negedge clk) begin
    if (rst3) pp3 = 1'b0;
    else begin
      chk("credit3", 64'(credit_out3), 64'(pp3));
      chk("occ3", 64'(occupancy3), 64'(q3.size()));
      chk("conserve3", 64'(int'(occupancy3) + int'(credit_out3) + int'(flit_valid_in3) + tx), 64'd3);
      if (flit_valid_out3 && flit_ready_in3) begin
        if (q3.size() == 0) chk("underflow3", 64'(flit_valid_out3), 64'h0);
        else chk("data3", flit_out3, q3.pop_front());
      end
      pp3 = flit_valid_out3 && flit_ready_in3;
    end
  end

  task automatic step(input logic [63:0] d, input logic v, input logic r, input logic acc);
    flit_in4 = d;
    flit_valid_in4 = v;
    flit_ready_in4 = r;
    @(posedge clk);
    if (acc) q4.push_back(d);
    #1;
  endtask

  task automatic fill4;
    for (int i = 1; i <= 4; i++) step(64'(i), 1'b1, 1'b0, 1'b1);
  endtask

  task automatic directed;
    step(64'hA5, 1'b1, 1'b1, 1'b1);
    chk("single_valid", 64'(flit_valid_out4), 64'h1);
    chk("single_data", flit_out4, 64'hA5);
    step(64'h0, 1'b0, 1'b1, 1'b0);
    chk("single_credit", 64'(credit_out4), 64'h1);
    chk("single_occ", 64'(occupancy4), 64'h0);
    step(64'h0, 1'b0, 1'b0, 1'b0);
    chk("single_credit_once", 64'(credit_out4), 64'h0);
    fill4();
    chk("fill_occ", 64'(occupancy4), 64'h4);
    repeat (4) step(64'h0, 1'b0, 1'b1, 1'b0);
    step(64'h0, 1'b0, 1'b0, 1'b0);
    chk("drain_occ", 64'(occupancy4), 64'h0);
    fill4();
    step(64'h5, 1'b1, 1'b1, 1'b1);
    chk("pushpop_occ", 64'(occupancy4), 64'h4);
    chk("pushpop_credit", 64'(credit_out4), 64'h1);
    chk("pushpop_ovf", 64'(overflow_err4), 64'h0);
    repeat (4) step(64'h0, 1'b0, 1'b1, 1'b0);
    step(64'h0, 1'b0, 1'b0, 1'b0);
    fill4();
    step(64'h9, 1'b1, 1'b0, 1'b0);
    chk("ovf_set", 64'(overflow_err4), 64'h1);
    chk("ovf_occ", 64'(occupancy4), 64'h4);
    repeat (4) step(64'h0, 1'b0, 1'b1, 1'b0);
    step(64'h0, 1'b0, 1'b0, 1'b0);
    chk("ovf_sticky", 64'(overflow_err4), 64'h1);
    step(64'h11, 1'b1, 1'b0, 1'b1);
    step(64'h22, 1'b1, 1'b0, 1'b1);
    step(64'h0, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_credit", 64'(credit_out4), 64'h1);
    flit_ready_in4 = 1'b0;
    #1 rst4 = 1'b1;
    #1;
    chk("rst_occ", 64'(occupancy4), 64'h0);
    chk("rst_valid", 64'(flit_valid_out4), 64'h0);
    chk("rst_data", flit_out4, 64'h0);
    chk("rst_credit", 64'(credit_out4), 64'h0);
    chk("rst_ovf", 64'(overflow_err4), 64'h0);
    q4.delete();
    repeat (2) @(posedge clk);
    #1 rst4 = 1'b0;
    repeat (4) step(64'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic stream(input int n, input bit drain);
    logic [63:0] d;
    logic c, s;
    for (int i = 0; i < n; i++) begin
      s = !drain && tx > 0 && $urandom_range(0, 1) == 1;
      d = {$urandom, $urandom};
      if (s) tx--;
      flit_in3 = d;
      flit_valid_in3 = s;
      flit_ready_in3 = drain || $urandom_range(0, 3) != 0;
      @(negedge clk);
      c = credit_out3;
      @(posedge clk);
      if (s) q3.push_back(d);
      if (c) tx++;
      #1;
    end
  endtask

  initial begin
    #1;
    chk("init_occ", 64'(occupancy4), 64'h0);
    chk("init_valid", 64'(flit_valid_out4), 64'h0);
    chk("init_data", flit_out4, 64'h0);
    chk("init_credit", 64'(credit_out4), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst4 = 1'b0;
    rst3 = 1'b0;
    fork
      directed();
      begin
        stream(10000, 1'b0);
        stream(20, 1'b1);
      end
    join
    chk("stream_drained", 64'(q3.size()), 64'h0);
    chk("stream_credits", 64'(tx), 64'h3);
    chk("stream_ovf", 64'(overflow_err3), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
